// File: rtl/riscv_muldiv_unit.sv
// riscv_muldiv_unit: iterative RV32M multiply/divide unit; define RISCV_MULDIV_FAST_MUL_EN for a single-cycle multiplier
module riscv_muldiv_unit #(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1,
  parameter int TAG_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [XLEN-1:0]  req_rs1,
  input  logic [XLEN-1:0]  req_rs2,
  input  logic [TAG_W-1:0] req_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [XLEN-1:0]  rsp_result,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             busy
);
  localparam int K  = XLEN / UNROLL;
  localparam int CW = $clog2(K);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_nxt;
  logic [2:0] op_q;
  logic [TAG_W-1:0] tag_q;
  logic [XLEN-1:0] hi, lo, b_q, hi_nxt, lo_nxt, a_abs, b_abs, result_nxt;
  logic [XLEN:0] sub, sum;
  logic [2*XLEN-1:0] prod;
  logic [CW-1:0] cnt;
  logic neg_q, rneg_q, a_sgn, b_sgn, a_neg, b_neg, accept, last;
  assign a_sgn = req_op[2] ? !req_op[0] : (req_op[1:0] == 2'b01 || req_op[1:0] == 2'b10);
  assign b_sgn = req_op[2] ? !req_op[0] : (req_op[1:0] == 2'b01);
  assign a_neg = a_sgn && req_rs1[XLEN-1];
  assign b_neg = b_sgn && req_rs2[XLEN-1];
  assign a_abs = a_neg ? -req_rs1 : req_rs1;
  assign b_abs = b_neg ? -req_rs2 : req_rs2;
  assign req_ready = !flush && (state == IDLE || (state == DONE && rsp_ready));
  assign accept = req_valid && req_ready;
  assign rsp_valid = state == DONE;
  assign busy = state != IDLE;
  // One compute step: UNROLL shift-add (multiply) or restoring-subtract (divide) iterations on {hi,lo}
  always_comb begin
    hi_nxt = hi;
    lo_nxt = lo;
    sub = '0;
    sum = '0;
    last = cnt == CW'(K - 1);
    for (int i = 0; i < UNROLL; i++) begin
      if (op_q[2]) begin
        sub = {hi_nxt, lo_nxt[XLEN-1]} - {1'b0, b_q};
        hi_nxt = sub[XLEN] ? {hi_nxt[XLEN-2:0], lo_nxt[XLEN-1]} : sub[XLEN-1:0];
        lo_nxt = {lo_nxt[XLEN-2:0], !sub[XLEN]};
      end else begin
        sum = {1'b0, hi_nxt} + (lo_nxt[0] ? {1'b0, b_q} : '0);
        lo_nxt = {sum[0], lo_nxt[XLEN-1:1]};
        hi_nxt = sum[XLEN:1];
      end
    end
`ifdef RISCV_MULDIV_FAST_MUL_EN
    if (!op_q[2]) begin
      {hi_nxt, lo_nxt} = (2*XLEN)'(lo) * (2*XLEN)'(b_q);
      last = 1'b1;
    end
`endif
  end
  // Sign fixup and result selection applied as the last step completes
  always_comb begin
    prod = neg_q ? -{hi_nxt, lo_nxt} : {hi_nxt, lo_nxt};
    result_nxt = op_q[2] ? (op_q[1] ? (rneg_q ? -hi_nxt : hi_nxt) : (neg_q ? -lo_nxt : lo_nxt))
                         : (op_q[1:0] == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
  end
  // Next state: flush wins, then accept, then completion, then response handshake
  always_comb begin
    state_nxt = state;
    if (flush) state_nxt = IDLE;
    else if (accept) state_nxt = CALC;
    else if (state == CALC && last) state_nxt = DONE;
    else if (state == DONE && rsp_ready) state_nxt = IDLE;
  end
  // State, operand latch, iteration and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rsp_result <= '0;
      rsp_tag <= '0;
    end else if (clk_en) begin
      state <= state_nxt;
      if (accept) begin
        op_q <= req_op;
        tag_q <= req_tag;
        hi <= '0;
        lo <= a_abs;
        b_q <= b_abs;
        neg_q <= req_op[2] ? (a_neg ^ b_neg) && |req_rs2 : a_neg ^ b_neg;
        rneg_q <= a_neg;
        cnt <= '0;
      end else if (state == CALC) begin
        hi <= hi_nxt;
        lo <= lo_nxt;
        cnt <= cnt + 1'b1;
        if (last && !flush) begin
          rsp_result <= result_nxt;
          rsp_tag <= tag_q;
        end
      end
    end
  end
endmodule

// File: tb/tb_riscv_muldiv_unit.sv
// tb_riscv_muldiv_unit: scoreboard bench for riscv_muldiv_unit (XLEN=32, UNROLL=1)
module tb_riscv_muldiv_unit;
  localparam int K = 32;
  logic clk = 0, rst = 1, clk_en = 1, flush = 0, req_valid = 0, req_ready, rsp_valid, rsp_ready = 1, busy;
  logic [2:0] req_op = 0;
  logic [31:0] req_rs1 = 0, req_rs2 = 0, rsp_result;
  logic [4:0] req_tag = 0, rsp_tag;
  int errors = 0, checks = 0, cyc = 0, first_cyc = 0, waits;
  logic seen = 0;
  typedef struct {logic [31:0] res; logic [4:0] tag; int acc; int lat;} exp_t;
  exp_t sb[$];
  exp_t e;
  riscv_muldiv_unit #(.XLEN(32), .UNROLL(1), .TAG_W(5)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .flush(flush), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_tag(req_tag), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_tag(rsp_tag), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask
  function automatic int lat_of(input logic [2:0] op);
`ifdef RISCV_MULDIV_FAST_MUL_EN
    return op[2] ? K : 1;
`else
    return K;
`endif
  endfunction
  // Monitor: records first rsp_valid cycle, pops and compares on each response handshake
  always @(negedge clk) begin
    if (!rst) begin
      if (rsp_valid && !seen) begin
        seen = 1;
        first_cyc = cyc;
      end
      if (rsp_valid && rsp_ready && clk_en) begin
        if (sb.size() == 0) chk("unexpected_rsp", 32'(rsp_tag), 32'hFFFF_FFFF);
        else begin
          e = sb.pop_front();
          chk("result", rsp_result, e.res);
          chk("tag", 32'(rsp_tag), 32'(e.tag));
          chk("latency", 32'(first_cyc - e.acc), 32'(e.lat));
        end
        seen = 0;
      end
    end else seen = 0;
  end
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag,
                       input logic [31:0] exp, input int extra, input bit expect_rsp);
    req_valid = 1; req_op = op; req_rs1 = a; req_rs2 = b; req_tag = tag;
    waits = 0;
    @(negedge clk);
    while (!(req_ready && clk_en) && waits < 200) begin
      waits++;
      @(negedge clk);
    end
    if (waits >= 200) chk("accept_timeout", 32'(waits), 32'd0);
    else if (expect_rsp) sb.push_back('{exp, tag, cyc + 1, lat_of(op) + extra});
    @(posedge clk); #1;
    req_valid = 0;
  endtask
  task automatic drain();
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(posedge clk);
    #1 chk("drain", 32'(sb.size()), 32'd0);
  endtask
  task automatic quiet(input string name);
    int hits = 0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (rsp_valid) hits++;
    end
    chk(name, 32'(hits), 32'd0);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_valid", 32'(rsp_valid), 0);
    chk("rst_result", rsp_result, 0);
    chk("rst_tag", 32'(rsp_tag), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(req_ready), 1);
    @(posedge clk); #1;
    issue(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd3, 32'hFFFF_FFEB, 0, 1);
    issue(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'hFFFF_FFFF, 0, 1);
    issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE, 0, 1);
    issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'h0000_0000, 0, 1);
    issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd5, 32'h8000_0000, 0, 1);
    issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 32'h0000_0000, 0, 1);
    issue(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFD, 0, 1);
    issue(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd8, 32'hFFFF_FFFF, 0, 1);
    issue(3'b101, 32'd5, 32'd0, 5'd9, 32'hFFFF_FFFF, 0, 1);
    issue(3'b111, 32'd5, 32'd0, 5'd10, 32'd5, 0, 1);
    issue(3'b100, 32'd100, 32'd7, 5'd11, 32'd14, 0, 1);
    issue(3'b110, 32'd100, 32'd7, 5'd12, 32'd2, 0, 1);
    issue(3'b100, 32'hFFFF_FFF9, 32'd0, 5'd13, 32'hFFFF_FFFF, 0, 1);
    issue(3'b110, 32'hFFFF_FFF9, 32'd0, 5'd14, 32'hFFFF_FFF9, 0, 1);
    issue(3'b000, 32'h1234_5678, 32'h10, 5'd15, 32'h2345_6780, 0, 1);
    issue(3'b011, 32'h8000_0000, 32'd4, 5'd16, 32'd2, 0, 1);
    drain();
    issue(3'b100, 32'd1000, 32'd3, 5'd17, 32'd333, 0, 0);
    repeat (9) @(posedge clk);
    #1 flush = 1; req_valid = 1; req_op = 3'b101; req_tag = 5'd18;
    @(negedge clk);
    chk("flush_beats_req", 32'(req_ready), 0);
    @(posedge clk); #1;
    flush = 0; req_valid = 0;
    @(negedge clk);
    chk("flush_ready", 32'(req_ready), 1);
    chk("flush_busy", 32'(busy), 0);
    quiet("flush_no_rsp");
    @(posedge clk); #1;
    issue(3'b100, 32'd1000, 32'd3, 5'd19, 32'd333, 0, 0);
    repeat (9) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("rst_mid_ready", 32'(req_ready), 1);
    chk("rst_mid_busy", 32'(busy), 0);
    quiet("rst_no_rsp");
    @(posedge clk); #1;
    rsp_ready = 0;
    issue(3'b000, 32'd7, 32'd3, 5'd20, 32'd21, 0, 1);
    for (int i = 0; i < 100 && !rsp_valid; i++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", 32'(rsp_valid), 1);
      chk("stall_result", rsp_result, 32'd21);
      chk("stall_tag", 32'(rsp_tag), 32'd20);
      if (i < 4) @(negedge clk);
    end
    @(posedge clk); #1;
    rsp_ready = 1;
    issue(3'b101, 32'd100, 32'd10, 5'd21, 32'd10, 0, 1);
    chk("same_edge_accept", 32'(waits), 0);
    drain();
    issue(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd22, 32'hFFFF_FFFD, 4, 1);
    repeat (5) @(posedge clk);
    #1 clk_en = 0;
    repeat (4) @(posedge clk);
    #1 clk_en = 1;
    drain();
    issue(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd23, 32'hFFFF_FFEB, 0, 1);
    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL global_timeout act=%0d exp=finish", cyc);
    $fatal(1, "timeout");
  end
endmodule
